key_event: RTL and testbench

- Sits directly downstream of the per-key debouncers; consumes their stable key levels and turns them into single-cycle key events for the vending-machine control FSM.
- Events: press, long-press, auto-repeat and release, each tagged with the key index.
- Only one key is tracked at a time, which gives the controller a clean, serialized event stream.

---
 rtl/key_pkg.sv | 28 ++
 rtl/key_event_if.sv | 32 +++
 rtl/prio_enc.sv | 27 ++
 rtl/key_event.sv | 179 +++++++++++++++++
 tb/tb_key_event.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the key event generator.
//   - Event type codes carried on evt_type.
//   - FSM state encoding (also exported as a debug output).
//   - Helper for sizing the hold/repeat counter.
package key_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_LONG    = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;
    localparam logic [1:0] EVT_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        HELD      = 2'b01,
        REPEAT    = 2'b10,
        LONG_WAIT = 2'b11
    } key_state_e;

    // Counter width able to hold max(a, b) - 1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_event_if.sv
// key_event_if: event stream from key_event to the controller.
//   evt_vld  : one-cycle event strobe
//   evt_type : event kind (key_pkg EVT_*), meaningful only with evt_vld
//   evt_code : index of the tracked key, meaningful only with evt_vld
//   held     : high while a key is being tracked
// Handshake: evt_vld is a pure strobe with no ready/backpressure; the
// consumer must accept an event in the single cycle evt_vld is high.
interface key_event_if #(
    parameter int NKEYS = 5
);
    localparam int CODE_W = $clog2(NKEYS);

    logic              evt_vld;
    logic [1:0]        evt_type;
    logic [CODE_W-1:0] evt_code;
    logic              held;

    modport master (
        output evt_vld,
        output evt_type,
        output evt_code,
        output held
    );

    modport slave (
        input evt_vld,
        input evt_type,
        input evt_code,
        input held
    );

endinterface

// File: rtl/prio_enc.sv
// prio_enc: combinational lowest-set-bit encoder.
//   req : request vector
//   idx : index of the lowest set bit of req (0 when req is all zero)
//   any : high when any bit of req is set
module prio_enc #(
    parameter int N = 5
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    // Scan from the top down so the lowest set bit is written last.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/key_event.sv
// key_event: turns debounced key levels into serialized single-cycle
// press / long / repeat / release events for one tracked key at a time.
//   clk       : system clock
//   nrst      : asynchronous active-low reset
//   key_lvl   : debounced key levels, 1 = pressed, synchronous to clk
//   evt       : event stream (key_event_if master)
//   state_dbg : current FSM state, for observation only
module key_event
    import key_pkg::*;
#(
    parameter int NKEYS      = 5,
    parameter int LONG_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000,
    parameter int REPEAT_EN  = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [NKEYS-1:0] key_lvl,
    key_event_if.master      evt,
    output key_state_e       state_dbg
);

    localparam int CODE_W = $clog2(NKEYS);
    localparam int CNT_W  = cnt_width(LONG_CYC, REPEAT_CYC);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    key_state_e        state_q,    state_d;
    logic [NKEYS-1:0]  key_prev_q, key_prev_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [CODE_W-1:0] active_q,   active_d;
    logic              evt_vld_q,  evt_vld_d;
    logic [1:0]        evt_type_q, evt_type_d;
    logic [CODE_W-1:0] evt_code_q, evt_code_d;
    logic              held_q,     held_d;

    logic [NKEYS-1:0]  rise;
    logic [CODE_W-1:0] rise_idx;
    logic              rise_any;
    logic              key_up;
    logic              long_hit;
    logic              rep_hit;

    assign key_prev_d = key_lvl;
    assign rise       = key_lvl & ~key_prev_q;

    prio_enc #(
        .N (NKEYS)
    ) u_prio_enc (
        .req (rise),
        .idx (rise_idx),
        .any (rise_any)
    );

    // Only the tracked key's level matters; other keys are ignored while held.
    assign key_up   = ~key_lvl[active_q];
    assign long_hit = (cnt_q == LONG_LAST);
    assign rep_hit  = (cnt_q == REPEAT_LAST);

    // State register plus counter, active key and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            key_prev_q <= '0;
            cnt_q      <= '0;
            active_q   <= '0;
            evt_vld_q  <= 1'b0;
            evt_type_q <= EVT_PRESS;
            evt_code_q <= '0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_prev_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            evt_vld_q  <= evt_vld_d;
            evt_type_q <= evt_type_d;
            evt_code_q <= evt_code_d;
            held_q     <= held_d;
        end
    end

    // Next-state, counter and active-key selection.
    // Release always wins over a threshold hit in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                if (rise_any) begin
                    active_d = rise_idx;
                    cnt_d    = '0;
                    state_d  = HELD;
                end
            end
            HELD: begin
                if (key_up) begin
                    state_d = IDLE;
                end else if (long_hit) begin
                    cnt_d   = '0;
                    state_d = (REPEAT_EN != 0) ? REPEAT : LONG_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (key_up) begin
                    state_d = IDLE;
                end else if (rep_hit) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG_WAIT: begin
                // Counter frozen; only the release matters here.
                if (key_up) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Event decode; registered so events appear the cycle after the decision.
    always_comb begin
        evt_vld_d  = 1'b0;
        evt_type_d = EVT_PRESS;
        evt_code_d = active_q;
        case (state_q)
            IDLE: begin
                if (rise_any) begin
                    evt_vld_d  = 1'b1;
                    evt_type_d = EVT_PRESS;
                    evt_code_d = rise_idx;
                end
            end
            HELD: begin
                if (key_up) begin
                    evt_vld_d  = 1'b1;
                    evt_type_d = EVT_RELEASE;
                end else if (long_hit) begin
                    evt_vld_d  = 1'b1;
                    evt_type_d = EVT_LONG;
                end
            end
            REPEAT: begin
                if (key_up) begin
                    evt_vld_d  = 1'b1;
                    evt_type_d = EVT_RELEASE;
                end else if (rep_hit) begin
                    evt_vld_d  = 1'b1;
                    evt_type_d = EVT_REPEAT;
                end
            end
            LONG_WAIT: begin
                if (key_up) begin
                    evt_vld_d  = 1'b1;
                    evt_type_d = EVT_RELEASE;
                end
            end
            default: begin
                evt_vld_d = 1'b0;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    assign evt.evt_vld  = evt_vld_q;
    assign evt.evt_type = evt_type_q;
    assign evt.evt_code = evt_code_q;
    assign evt.held     = held_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed bench for key_event with LONG_CYC = 10,
// REPEAT_CYC = 4, NKEYS = 5. dut_a has auto-repeat enabled, dut_b does not.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_event;
    import key_pkg::*;

    logic       clk;
    logic       nrst;
    logic [4:0] key_a;
    logic [4:0] key_b;
    key_state_e state_a;
    key_state_e state_b;

    int tests;
    int fails;

    key_event_if #(.NKEYS(5)) if_a ();
    key_event_if #(.NKEYS(5)) if_b ();

    key_event #(
        .NKEYS      (5),
        .LONG_CYC   (10),
        .REPEAT_CYC (4),
        .REPEAT_EN  (1)
    ) u_dut_a (
        .clk       (clk),
        .nrst      (nrst),
        .key_lvl   (key_a),
        .evt       (if_a),
        .state_dbg (state_a)
    );

    key_event #(
        .NKEYS      (5),
        .LONG_CYC   (10),
        .REPEAT_CYC (4),
        .REPEAT_EN  (0)
    ) u_dut_b (
        .clk       (clk),
        .nrst      (nrst),
        .key_lvl   (key_b),
        .evt       (if_b),
        .state_dbg (state_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cmp(input string tag, input int c, input logic [7:0] got,
                       input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s c%0d: got %0h expected %0h", tag, c, got, exp);
        end
    endtask

    // Check one sampled cycle of a DUT: event strobe, type/code when an event
    // is expected, and the held flag.
    task automatic chk(input bit sel_b, input string tag, input int c,
                       input bit ev, input logic [1:0] typ,
                       input logic [2:0] code, input bit hld);
        logic       vld;
        logic [1:0] t;
        logic [2:0] k;
        logic       h;
        vld = sel_b ? if_b.evt_vld  : if_a.evt_vld;
        t   = sel_b ? if_b.evt_type : if_a.evt_type;
        k   = sel_b ? if_b.evt_code : if_a.evt_code;
        h   = sel_b ? if_b.held     : if_a.held;
        cmp({tag, "_vld"}, c, {7'd0, vld}, {7'd0, ev});
        if (ev) begin
            cmp({tag, "_type"}, c, {6'd0, t}, {6'd0, typ});
            cmp({tag, "_code"}, c, {5'd0, k}, {5'd0, code});
        end
        cmp({tag, "_held"}, c, {7'd0, h}, {7'd0, hld});
    endtask

    initial begin
        bit         ev;
        logic [1:0] typ;
        logic [2:0] code;

        tests = 0;
        fails = 0;
        nrst  = 1'b0;
        key_a = '0;
        key_b = '0;

        // Reset state
        tick();
        tick();
        cmp("rst_a_vld",  0, {7'd0, if_a.evt_vld},  8'd0);
        cmp("rst_a_type", 0, {6'd0, if_a.evt_type}, 8'd0);
        cmp("rst_a_code", 0, {5'd0, if_a.evt_code}, 8'd0);
        cmp("rst_a_held", 0, {7'd0, if_a.held},     8'd0);
        cmp("rst_a_state", 0, {6'd0, state_a},      {6'd0, IDLE});
        cmp("rst_b_vld",  0, {7'd0, if_b.evt_vld},  8'd0);
        cmp("rst_b_held", 0, {7'd0, if_b.held},     8'd0);
        nrst = 1'b1;
        tick();
        tick();

        // Short tap on key 2: high for 5 sampled cycles.
        key_a = 5'b00100;
        for (int c = 1; c <= 7; c++) begin
            tick();
            ev = (c == 1) || (c == 6);
            typ = (c == 6) ? EVT_RELEASE : EVT_PRESS;
            chk(1'b0, "tap", c, ev, typ, 3'd2, c < 6);
            if (c == 5) key_a = '0;
        end

        // Long hold on key 0: press, long +10, repeats +14/+18/+22, release.
        key_a = 5'b00001;
        for (int c = 1; c <= 27; c++) begin
            tick();
            ev  = 1'b1;
            typ = EVT_PRESS;
            if (c == 1)                             typ = EVT_PRESS;
            else if (c == 11)                       typ = EVT_LONG;
            else if (c == 15 || c == 19 || c == 23) typ = EVT_REPEAT;
            else if (c == 26)                       typ = EVT_RELEASE;
            else                                    ev  = 1'b0;
            chk(1'b0, "hold", c, ev, typ, 3'd0, c < 26);
            if (c == 12) cmp("hold_state", c, {6'd0, state_a}, {6'd0, REPEAT});
            if (c == 25) key_a = '0;
        end

        // Simultaneous rise on keys 1 and 4: key 1 wins, key 4 ignored.
        key_a = 5'b10010;
        for (int c = 1; c <= 10; c++) begin
            tick();
            ev   = (c == 1) || (c == 6) || (c == 8) || (c == 9);
            typ  = (c == 6 || c == 9) ? EVT_RELEASE : EVT_PRESS;
            code = (c >= 8) ? 3'd4 : 3'd1;
            chk(1'b0, "simul", c, ev, typ, code, (c < 6) || (c == 8));
            if (c == 3) key_a = 5'b00010;
            if (c == 5) key_a = 5'b00000;
            if (c == 7) key_a = 5'b10000;
            if (c == 8) key_a = 5'b00000;
        end

        // Key 3 rises while key 2 is tracked; it never produces events.
        key_a = 5'b00100;
        for (int c = 1; c <= 9; c++) begin
            tick();
            ev  = (c == 1) || (c == 5);
            typ = (c == 5) ? EVT_RELEASE : EVT_PRESS;
            chk(1'b0, "other", c, ev, typ, 3'd2, c < 5);
            if (c == 2) key_a = 5'b01100;
            if (c == 4) key_a = 5'b01000;
            if (c == 7) key_a = 5'b00000;
        end

        // Release of key 0 and rise of key 1 in the same cycle.
        key_a = 5'b00001;
        for (int c = 1; c <= 6; c++) begin
            tick();
            ev  = (c == 1) || (c == 3);
            typ = (c == 3) ? EVT_RELEASE : EVT_PRESS;
            chk(1'b0, "swap", c, ev, typ, 3'd0, c < 3);
            if (c == 2) key_a = 5'b00010;
            if (c == 5) key_a = 5'b00000;
        end

        // Release sampled exactly when the long threshold is reached.
        key_a = 5'b00001;
        for (int c = 1; c <= 13; c++) begin
            tick();
            ev  = (c == 1) || (c == 11);
            typ = (c == 11) ? EVT_RELEASE : EVT_PRESS;
            chk(1'b0, "thresh", c, ev, typ, 3'd0, c < 11);
            if (c == 10) key_a = '0;
        end

        // Asynchronous reset while a repeat event is on the outputs.
        key_a = 5'b00001;
        for (int c = 1; c <= 15; c++) begin
            tick();
            ev  = 1'b1;
            typ = EVT_PRESS;
            if (c == 1)       typ = EVT_PRESS;
            else if (c == 11) typ = EVT_LONG;
            else if (c == 15) typ = EVT_REPEAT;
            else              ev  = 1'b0;
            chk(1'b0, "prerst", c, ev, typ, 3'd0, 1'b1);
        end
        #1 nrst = 1'b0;
        #1;
        cmp("arst_vld",  0, {7'd0, if_a.evt_vld},  8'd0);
        cmp("arst_type", 0, {6'd0, if_a.evt_type}, 8'd0);
        cmp("arst_code", 0, {5'd0, if_a.evt_code}, 8'd0);
        cmp("arst_held", 0, {7'd0, if_a.held},     8'd0);
        cmp("arst_state", 0, {6'd0, state_a},      {6'd0, IDLE});
        tick();
        chk(1'b0, "inrst", 1, 1'b0, EVT_PRESS, 3'd0, 1'b0);
        tick();
        chk(1'b0, "inrst", 2, 1'b0, EVT_PRESS, 3'd0, 1'b0);
        nrst = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            ev  = (c == 1) || (c == 2);
            typ = (c == 2) ? EVT_RELEASE : EVT_PRESS;
            chk(1'b0, "postrst", c, ev, typ, 3'd0, c == 1);
            if (c == 1) key_a = '0;
        end

        // No auto-repeat: press, long at +10, then silence until release.
        key_b = 5'b00100;
        for (int c = 1; c <= 32; c++) begin
            tick();
            ev  = (c == 1) || (c == 11) || (c == 31);
            typ = (c == 11) ? EVT_LONG : ((c == 31) ? EVT_RELEASE : EVT_PRESS);
            chk(1'b1, "norep", c, ev, typ, 3'd2, c < 31);
            if (c == 20) cmp("norep_state", c, {6'd0, state_b}, {6'd0, LONG_WAIT});
            if (c == 30) key_b = '0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
